ahbl_decode_mux: RTL and testbench

//  Parametrised AHB-Lite address decoder and slave-to-master response mux for the Cortex-M0 system bus.

---
 rtl/ahbl_decode_mux.sv | 163 ++++++++++++++++
 tb/tb_ahbl_decode_mux.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ahbl_decode_mux.sv
// AHB-Lite address decoder and response mux with a built-in 2-cycle ERROR default slave.
// Optional wait-state timeout and hung-slave masking when AHBL_DMUX_TIMEOUT_EN is defined.
module ahbl_decode_mux #(
  parameter int                NSLV        = 4,
  parameter logic [NSLV*8-1:0] SLV_BASE    = {8'h52, 8'h51, 8'h50, 8'h00},
  parameter logic [31:0]       NOMAP_DATA  = 32'hDEADBEEF,
  parameter int                TIMEOUT_CYC = 1024
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  output logic [NSLV-1:0]    HSEL_S,
  input  logic [NSLV*32-1:0] HRDATA_S,
  input  logic [NSLV-1:0]    HREADYOUT_S,
  input  logic [NSLV-1:0]    HRESP_S,
  output logic [31:0]        HRDATA,
  output logic               HREADY,
  output logic               HRESP,
  output logic               TIMEOUT
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  // state   | meaning
  // DS_IDLE | no default-slave response in progress
  // DS_ERR1 | first ERROR cycle, HREADY low
  // DS_ERR2 | second ERROR cycle, HREADY high
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_t;

  ds_t             r_ds;
  logic [IW-1:0]   r_idx;
  logic            r_valid;
  logic            r_nomap;
  logic            r_seen;
  logic [NSLV-1:0] w_hung;
  logic [NSLV-1:0] w_hit;
  logic [IW-1:0]   w_idx;
  logic            w_nomap;
  logic            w_active;
  logic            w_load;
  logic            w_timeout;
  logic            w_sel_rdy;
  logic            w_sel_resp;
  logic [31:0]     w_sel_data;
  logic [31:0]     w_rdata [NSLV];
  logic            w_unused;

  assign w_unused = ^{HADDR[23:0], HTRANS[0]};

  genvar g;
  generate
    for (g = 0; g < NSLV; g++) begin : g_rdata
      assign w_rdata[g] = HRDATA_S[32*g +: 32];
    end
  endgenerate

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    w_hit   = '0;
    w_idx   = '0;
    w_nomap = 1'b1;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((HADDR[31:24] == SLV_BASE[8*i +: 8]) && !w_hung[i]) begin
        w_hit    = '0;
        w_hit[i] = 1'b1;
        w_idx    = IW'(i);
        w_nomap  = 1'b0;
      end
    end
  end

  assign HSEL_S     = w_hit;
  assign w_active   = HTRANS[1];
  assign w_load     = HREADY;
  assign w_sel_rdy  = HREADYOUT_S[r_idx];
  assign w_sel_resp = HRESP_S[r_idx];
  assign w_sel_data = w_rdata[r_idx];

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = r_seen ? w_sel_data : 32'h0;
    case (r_ds)
      DS_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
        HRDATA = NOMAP_DATA;
      end
      DS_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
        HRDATA = NOMAP_DATA;
      end
      default: begin
        if (r_valid && !r_nomap) begin
          HREADY = w_sel_rdy;
          HRESP  = w_sel_resp;
          HRDATA = w_sel_data;
        end
      end
    endcase
  end

  // Index only follows active mapped transfers so idle phases keep showing the last slave.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_valid <= 1'b0;
      r_nomap <= 1'b0;
      r_seen  <= 1'b0;
      r_idx   <= '0;
    end else if (w_load) begin
      r_valid <= w_active;
      r_nomap <= w_nomap;
      if (w_active && !w_nomap) begin
        r_idx  <= w_idx;
        r_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ds <= DS_IDLE;
    end else begin
      case (r_ds)
        DS_IDLE: if (w_timeout || (w_load && w_active && w_nomap)) r_ds <= DS_ERR1;
        DS_ERR1: r_ds <= DS_ERR2;
        DS_ERR2: r_ds <= (w_active && w_nomap) ? DS_ERR1 : DS_IDLE;
        default: r_ds <= DS_IDLE;
      endcase
    end
  end

`ifdef AHBL_DMUX_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0]     r_cnt;
  logic [NSLV-1:0] r_hung;
  logic            w_stall;

  assign w_stall   = (r_ds == DS_IDLE) && r_valid && !r_nomap && !w_sel_rdy;
  assign w_timeout = w_stall && (r_cnt == TO_LAST);
  assign w_hung    = r_hung;
  assign TIMEOUT   = w_timeout;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt  <= '0;
      r_hung <= '0;
    end else begin
      r_cnt  <= (w_stall && !w_timeout) ? r_cnt + 16'd1 : 16'd0;
      r_hung <= r_hung & ~HREADYOUT_S;
      if (w_timeout) r_hung[r_idx] <= 1'b1;
    end
  end
`else
  assign w_hung    = '0;
  assign w_timeout = 1'b0;
  assign TIMEOUT   = 1'b0;
`endif

endmodule

// File: tb/tb_ahbl_decode_mux.sv
// Scoreboard bench for ahbl_decode_mux: directed cycles push expectations, a negedge monitor checks them.
module tb_ahbl_decode_mux;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'hA5A5_0001;
  localparam logic [31:0] D2 = 32'h2222_0002;
  localparam logic [31:0] D3 = 32'h3333_0003;
  localparam logic [31:0] NM = 32'hDEADBEEF;
  localparam logic [1:0]  N  = 2'b10;
  localparam logic [1:0]  I  = 2'b00;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic [31:0]  HADDR = 32'h6000_0000;
  logic [1:0]   HTRANS = 2'b00;
  logic [127:0] HRDATA_S;
  logic [3:0]   rdy_s = 4'hF;
  logic [3:0]   resp_s = 4'h0;
  logic [3:0]   hsel, hsel2;
  logic [31:0]  hrdata, d2_rdata;
  logic         hready, hresp, tmo, d2_ready, d2_resp, d2_tmo;

  always #5 HCLK = ~HCLK;
  assign HRDATA_S = {D3, D2, D1, D0};

  ahbl_decode_mux #(.TIMEOUT_CYC(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL_S(hsel),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(rdy_s), .HRESP_S(resp_s),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .TIMEOUT(tmo));

  ahbl_decode_mux #(.SLV_BASE({8'h52, 8'h50, 8'h50, 8'h00})) dut_dup (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL_S(hsel2),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(rdy_s), .HRESP_S(resp_s),
    .HRDATA(d2_rdata), .HREADY(d2_ready), .HRESP(d2_resp), .TIMEOUT(d2_tmo));

  typedef struct {
    logic [3:0]  hsel;
    logic [3:0]  hsel2;
    logic        rdy;
    logic        resp;
    logic        chk;
    logic [31:0] data;
    logic        to;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t x;
  int   errors = 0;
  int   checks = 0;

  task automatic check1(string nm, string f, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
    end
  endtask

  task automatic cyc(string nm, logic [31:0] a, logic [1:0] t, logic [3:0] r, logic [3:0] e,
                     logic [3:0] eh, logic [3:0] eh2, logic erdy, logic eresp, logic echk,
                     logic [31:0] edata, logic eto);
    exp_t n;
    @(posedge HCLK);
    #1;
    HADDR  = a;
    HTRANS = t;
    rdy_s  = r;
    resp_s = e;
    n.hsel = eh; n.hsel2 = eh2; n.rdy = erdy; n.resp = eresp;
    n.chk = echk; n.data = edata; n.to = eto; n.name = nm;
    q.push_back(n);
  endtask

  initial begin
    forever begin
      @(negedge HCLK);
      if (q.size() > 0) begin
        x = q.pop_front();
        check1(x.name, "hsel", {28'h0, hsel}, {28'h0, x.hsel});
        check1(x.name, "hsel_dup", {28'h0, hsel2}, {28'h0, x.hsel2});
        check1(x.name, "hready", {31'h0, hready}, {31'h0, x.rdy});
        check1(x.name, "hresp", {31'h0, hresp}, {31'h0, x.resp});
        check1(x.name, "timeout", {31'h0, tmo}, {31'h0, x.to});
        if (x.chk) check1(x.name, "hrdata", hrdata, x.data);
      end
    end
  end

  initial begin
    cyc("rst0", 32'h6000_0000, I, 4'hF, 4'h0, 4'h0, 4'h0, 1, 0, 1, 32'h0, 0);
    cyc("rst1", 32'h6000_0000, I, 4'hF, 4'h0, 4'h0, 4'h0, 1, 0, 1, 32'h0, 0);
    @(negedge HCLK); #1 HRESETn = 1'b1;

    cyc("t1_addr",  32'h5000_0004, N, 4'hF,    4'h0, 4'b0010, 4'b0010, 1, 0, 1, 32'h0, 0);
    cyc("t1_w1",    32'h6000_0000, I, 4'b1101, 4'h0, 4'h0, 4'h0, 0, 0, 0, 32'h0, 0);
    cyc("t1_w2",    32'h6000_0000, I, 4'b1101, 4'h0, 4'h0, 4'h0, 0, 0, 0, 32'h0, 0);
    cyc("t1_data",  32'h6000_0000, I, 4'hF,    4'h0, 4'h0, 4'h0, 1, 0, 1, D1, 0);
    cyc("idle_hold",32'h6000_0000, N, 4'hF,    4'h0, 4'h0, 4'h0, 1, 0, 1, D1, 0);
    cyc("nm_err1",  32'h6000_0000, I, 4'hF,    4'h0, 4'h0, 4'h0, 0, 1, 1, NM, 0);
    cyc("nm_err2",  32'h6000_0000, I, 4'hF,    4'h0, 4'h0, 4'h0, 1, 1, 1, NM, 0);
    cyc("nm_idleok",32'h0000_0000, N, 4'hF,    4'h0, 4'b0001, 4'b0001, 1, 0, 1, D1, 0);
    cyc("b2b_s0",   32'h5100_0000, N, 4'hF,    4'h0, 4'b0100, 4'h0, 1, 0, 1, D0, 0);
    cyc("b2b_s2",   32'h5200_0000, N, 4'hF,    4'h0, 4'b1000, 4'b1000, 1, 0, 1, D2, 0);
    cyc("s3_err1",  32'h6000_0000, I, 4'b0111, 4'b1000, 4'h0, 4'h0, 0, 1, 0, 32'h0, 0);
    cyc("s3_err2",  32'h6000_0000, I, 4'hF,    4'b1000, 4'h0, 4'h0, 1, 1, 1, D3, 0);
    cyc("idle_d3",  32'h7000_0000, N, 4'hF,    4'h0, 4'h0, 4'h0, 1, 0, 1, D3, 0);
    cyc("rr_err1",  32'h7000_0000, N, 4'hF,    4'h0, 4'h0, 4'h0, 0, 1, 1, NM, 0);
    cyc("rr_err2",  32'h7000_0000, N, 4'hF,    4'h0, 4'h0, 4'h0, 1, 1, 1, NM, 0);
    cyc("rr2_err1", 32'h6000_0000, I, 4'hF,    4'h0, 4'h0, 4'h0, 0, 1, 1, NM, 0);
    cyc("rr2_err2", 32'h6000_0000, I, 4'hF,    4'h0, 4'h0, 4'h0, 1, 1, 1, NM, 0);
    cyc("rr_idle",  32'h5000_0000, N, 4'hF,    4'h0, 4'b0010, 4'b0010, 1, 0, 1, D3, 0);
    cyc("rst_wait", 32'h5000_0000, N, 4'b1101, 4'h0, 4'b0010, 4'b0010, 0, 0, 0, 32'h0, 0);
    @(negedge HCLK); #1 HRESETn = 1'b0;
    cyc("rst_mid",  32'h5000_0000, N, 4'b1101, 4'h0, 4'b0010, 4'b0010, 1, 0, 1, 32'h0, 0);
    @(negedge HCLK); #1 HRESETn = 1'b1;
    cyc("post_rst", 32'h6000_0000, I, 4'hF,    4'h0, 4'h0, 4'h0, 1, 0, 1, D1, 0);
    cyc("post_idle",32'h6000_0000, I, 4'hF,    4'h0, 4'h0, 4'h0, 1, 0, 1, D1, 0);

`ifdef AHBL_DMUX_TIMEOUT_EN
    cyc("to_addr",  32'h5200_0000, N, 4'hF, 4'h0, 4'b1000, 4'b1000, 1, 0, 1, D1, 0);
    for (int k = 1; k <= 8; k++)
      cyc("to_wait", 32'h5200_0000, N, 4'b0111, 4'h0, 4'b1000, 4'b1000, 0, 0, 0, 32'h0, (k == 8));
    cyc("to_err1",  32'h5200_0000, N, 4'b0111, 4'h0, 4'h0, 4'b1000, 0, 1, 1, NM, 0);
    cyc("to_err2",  32'h5200_0000, N, 4'b0111, 4'h0, 4'h0, 4'b1000, 1, 1, 1, NM, 0);
    cyc("hung_err1",32'h6000_0000, I, 4'b0111, 4'h0, 4'h0, 4'h0, 0, 1, 1, NM, 0);
    cyc("hung_err2",32'h6000_0000, I, 4'b0111, 4'h0, 4'h0, 4'h0, 1, 1, 1, NM, 0);
    cyc("hung_rel", 32'h6000_0000, I, 4'hF,    4'h0, 4'h0, 4'h0, 1, 0, 1, D3, 0);
    cyc("hung_back",32'h5200_0000, N, 4'hF,    4'h0, 4'b1000, 4'b1000, 1, 0, 1, D3, 0);
    cyc("hung_data",32'h6000_0000, I, 4'hF,    4'h0, 4'h0, 4'h0, 1, 0, 1, D3, 0);
`endif

    for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge HCLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
